dp_split_sched: RTL and testbench



---
 rtl/dp_split_sched_if.sv | 31 +++
 rtl/dp_split_sched.sv | 171 +++++++++++++++++
 tb/tb_dp_split_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dp_split_sched_if.sv
// Handshake bundle between the DP split scheduler and its NTT cores / madd engine.
// master = scheduler side, slave = core/engine/requester side.
interface dp_split_sched_if #(
    parameter int NUM_POLY = 3,
    parameter int SPLIT_W  = 2
);
    logic                i_start;
    logic                i_mode;
    logic [SPLIT_W:0]    i_num_split;
    logic                o_busy;
    logic                o_done;
    logic                o_err;
    logic                o_ntt_start;
    logic [NUM_POLY-1:0] i_ntt_done;
    logic [NUM_POLY-1:0] o_ntt_done_mask;
    logic                o_madd_start;
    logic                i_madd_done;
    logic [SPLIT_W-1:0]  o_idx_split;

    modport master (
        input  i_start, i_mode, i_num_split, i_ntt_done, i_madd_done,
        output o_busy, o_done, o_err, o_ntt_start, o_ntt_done_mask,
               o_madd_start, o_idx_split
    );

    modport slave (
        output i_start, i_mode, i_num_split, i_ntt_done, i_madd_done,
        input  o_busy, o_done, o_err, o_ntt_start, o_ntt_done_mask,
               o_madd_start, o_idx_split
    );
endinterface

// File: rtl/dp_split_sched.sv
// Runs 1..NUM_SPLIT splits of NTT-then-madd (or madd only) per start; optional watchdog via DP_SPLIT_SCHED_WDOG_EN.
// Latency: one edge from start or final done rise to the next pulse; no backpressure, waits on done rising edges.
module dp_split_sched #(
    parameter int NUM_POLY  = 3,
    parameter int NUM_SPLIT = 4,
    parameter int SPLIT_W   = 2,
    parameter int WDOG_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    dp_split_sched_if.master  bus
);

    if ((1 << SPLIT_W) < NUM_SPLIT || WDOG_W < 2) begin : g_bad_param
        $error("dp_split_sched: SPLIT_W too narrow for NUM_SPLIT or WDOG_W < 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NTT_WAIT,
        ST_MADD_WAIT
    } state_t;

    localparam logic [SPLIT_W:0] MAX_N = (SPLIT_W+1)'(NUM_SPLIT);

    state_t              r_state, w_state_nxt;
    logic [SPLIT_W-1:0]  r_split, w_split_nxt;
    logic [SPLIT_W:0]    r_last, w_last_nxt, w_n_eff;
    logic                r_mode, w_mode_nxt;
    logic [NUM_POLY-1:0] r_mask, w_mask_nxt, w_mask_or;
    logic [NUM_POLY-1:0] r_ntt_prev, w_ntt_rise;
    logic                r_madd_prev, w_madd_rise;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic                r_ntt_start, w_ntt_start_nxt;
    logic                r_madd_start, w_madd_start_nxt;

    assign w_ntt_rise  = bus.i_ntt_done & ~r_ntt_prev;
    assign w_madd_rise = bus.i_madd_done & ~r_madd_prev;
    assign w_mask_or   = r_mask | w_ntt_rise;

    // Zero or out-of-range split count means a full run.
    assign w_n_eff = (bus.i_num_split == '0 || bus.i_num_split > MAX_N) ? MAX_N : bus.i_num_split;

`ifdef DP_SPLIT_SCHED_WDOG_EN
    logic [WDOG_W-1:0] r_wdog, w_wdog_inc;
    logic              w_wdog_hit;

    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_wdog_hit = (r_state != ST_IDLE) && (&w_wdog_inc);

    // Every state entry coincides with a start pulse or a return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE || w_ntt_start_nxt || w_madd_start_nxt) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_inc;
        end
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_split_nxt      = r_split;
        w_last_nxt       = r_last;
        w_mode_nxt       = r_mode;
        w_mask_nxt       = r_mask;
        w_busy_nxt       = r_busy;
        w_err_nxt        = r_err;
        w_done_nxt       = 1'b0;
        w_ntt_start_nxt  = 1'b0;
        w_madd_start_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_mode_nxt  = bus.i_mode;
                    w_last_nxt  = w_n_eff - 1'b1;
                    w_split_nxt = '0;
                    w_mask_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    if (bus.i_mode) begin
                        w_madd_start_nxt = 1'b1;
                        w_state_nxt      = ST_MADD_WAIT;
                    end else begin
                        w_ntt_start_nxt = 1'b1;
                        w_state_nxt     = ST_NTT_WAIT;
                    end
                end
            end
            ST_NTT_WAIT: begin
                w_mask_nxt = w_mask_or;
                if (&w_mask_or) begin
                    w_madd_start_nxt = 1'b1;
                    w_mask_nxt       = '0;
                    w_state_nxt      = ST_MADD_WAIT;
                end
            end
            ST_MADD_WAIT: begin
                if (w_madd_rise) begin
                    if ({1'b0, r_split} == r_last) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_split_nxt = r_split + 1'b1;
                        if (r_mode) begin
                            w_madd_start_nxt = 1'b1;
                        end else begin
                            w_ntt_start_nxt = 1'b1;
                            w_state_nxt     = ST_NTT_WAIT;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef DP_SPLIT_SCHED_WDOG_EN
        // Progress on the expiring cycle wins over the timeout.
        if (w_wdog_hit && !w_ntt_start_nxt && !w_madd_start_nxt && !w_done_nxt) begin
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_mask_nxt  = '0;
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_split      <= '0;
            r_last       <= '0;
            r_mode       <= 1'b0;
            r_mask       <= '0;
            r_ntt_prev   <= '0;
            r_madd_prev  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ntt_start  <= 1'b0;
            r_madd_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_split      <= w_split_nxt;
            r_last       <= w_last_nxt;
            r_mode       <= w_mode_nxt;
            r_mask       <= w_mask_nxt;
            r_ntt_prev   <= bus.i_ntt_done;
            r_madd_prev  <= bus.i_madd_done;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_ntt_start  <= w_ntt_start_nxt;
            r_madd_start <= w_madd_start_nxt;
        end
    end

    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_err           = r_err;
    assign bus.o_ntt_start     = r_ntt_start;
    assign bus.o_madd_start    = r_madd_start;
    assign bus.o_ntt_done_mask = r_mask;
    assign bus.o_idx_split     = r_split;

endmodule

// File: tb/tb_dp_split_sched.sv
// Scoreboard bench: the stimulus plans each run's event list (kind, split, cycle) from the
// run rules and a monitor pops one entry for every start/done pulse the scheduler emits.
module tb_dp_split_sched;
    localparam int NUM_POLY  = 3;
    localparam int NUM_SPLIT = 4;
    localparam int SPLIT_W   = 2;
    localparam int K_NTT = 0, K_MADD = 1, K_DONE = 2;

    typedef struct {
        int kind;
        int idx;
        int at;
        bit err;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    evt_t exp_q[$];

    dp_split_sched_if #(.NUM_POLY(NUM_POLY), .SPLIT_W(SPLIT_W)) b ();

    dp_split_sched #(
        .NUM_POLY (NUM_POLY),
        .NUM_SPLIT(NUM_SPLIT),
        .SPLIT_W  (SPLIT_W),
        .WDOG_W   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int idx, input int at, input bit err);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.at   = at;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        evt_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL evt: got unexpected kind=%0d idx=%0d at cyc %0d, expected no event",
                     kind, int'(b.o_idx_split), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.at != cyc || (e.idx >= 0 && e.idx != int'(b.o_idx_split)) ||
            int'(b.o_busy) != int'(kind != K_DONE) || int'(b.o_err) != int'(e.err)) begin
            fails++;
            $display("FAIL evt: got kind=%0d idx=%0d cyc=%0d busy=%0d err=%0d, expected kind=%0d idx=%0d cyc=%0d err=%0d",
                     kind, int'(b.o_idx_split), cyc, int'(b.o_busy), int'(b.o_err),
                     e.kind, e.idx, e.at, int'(e.err));
        end
    endtask

    always @(negedge clk) begin
        if (b.o_ntt_start)  take(K_NTT);
        if (b.o_madd_start) take(K_MADD);
        if (b.o_done)       take(K_DONE);
    end

    task automatic idle_inputs();
        b.i_start     = 1'b0;
        b.i_ntt_done  = '0;
        b.i_madd_done = 1'b0;
    endtask

    // pat: 0 random with spurious events, 1 directed NTT delays, 2 core0 held high across splits.
    task automatic run(input bit mode, input int num, input int pat, input int abort_s);
        int  n, t0, t1, maxd, dm, kd, em;
        int  d [NUM_POLY];
        bit  hold;
        hold = (pat == 2);
        n = (num == 0 || num > NUM_SPLIT) ? NUM_SPLIT : num;
        @(negedge clk);
        b.i_start     = 1'b1;
        b.i_mode      = mode;
        b.i_num_split = 3'(num);
        t0 = cyc + 1;
        push(mode ? K_MADD : K_NTT, 0, t0, 1'b0);
        for (int s = 0; s < n; s++) begin
            t1 = t0;
            if (!mode) begin
                for (int p = 0; p < NUM_POLY; p++) d[p] = int'($urandom_range(0, 6));
                if (pat == 1 && s == 0) begin d[0] = 5; d[1] = 9; d[2] = 7; end
                if (hold && s == 0) begin d[0] = 1; d[1] = 3; d[2] = 2; end
                if (hold && s == 1) begin d[0] = 6; d[1] = 1; d[2] = 2; end
                maxd = 0;
                for (int p = 0; p < NUM_POLY; p++) if (d[p] > maxd) maxd = d[p];
                kd = (maxd > 0) ? int'($urandom_range(0, maxd - 1)) : -1;
                for (int k = 0; k <= maxd; k++) begin
                    @(negedge clk);
                    em = 0;
                    for (int p = 0; p < NUM_POLY; p++) if (d[p] < k) em |= (1 << p);
                    chk("ntt_mask", int'(b.o_ntt_done_mask), em);
                    chk("ntt_idx", int'(b.o_idx_split), s);
                    chk("ntt_busy", int'(b.o_busy), 1);
                    b.i_start = 1'($urandom_range(0, 1));
                    for (int p = 0; p < NUM_POLY; p++)
                        b.i_ntt_done[p] = (d[p] == k) ||
                            (hold && p == 0 && ((s == 0 && k >= d[0]) || (s == 1 && k < 4)));
                    b.i_madd_done = (k == kd);
                end
                t1 = t0 + maxd + 1;
                push(K_MADD, s, t1, 1'b0);
            end
            dm = (abort_s == s) ? 4 : int'($urandom_range(1, 5));
            for (int k = 0; k <= dm; k++) begin
                @(negedge clk);
                if (abort_s == s && k == 1) begin
                    rst = 1'b1;
                    idle_inputs();
                    @(negedge clk);
                    chk("abort_busy", int'(b.o_busy), 0);
                    chk("abort_done", int'(b.o_done), 0);
                    chk("abort_err", int'(b.o_err), 0);
                    chk("abort_ntt_start", int'(b.o_ntt_start), 0);
                    chk("abort_madd_start", int'(b.o_madd_start), 0);
                    chk("abort_mask", int'(b.o_ntt_done_mask), 0);
                    chk("abort_idx", int'(b.o_idx_split), 0);
                    rst = 1'b0;
                    exp_q.delete();
                    return;
                end
                chk("madd_idx", int'(b.o_idx_split), s);
                chk("madd_busy", int'(b.o_busy), 1);
                chk("madd_mask", int'(b.o_ntt_done_mask), 0);
                b.i_start     = 1'($urandom_range(0, 1));
                b.i_madd_done = (k == dm);
                for (int p = 0; p < NUM_POLY; p++)
                    b.i_ntt_done[p] = (hold && s == 0 && p == 0) ||
                        (pat == 0 && k < dm && $urandom_range(0, 3) == 0);
            end
            t0 = t1 + dm + 1;
            if (s == n - 1) push(K_DONE, -1, t0, 1'b0);
            else            push(mode ? K_MADD : K_NTT, s + 1, t0, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        chk("end_busy", int'(b.o_busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;
        idle_inputs();
        b.i_mode      = 1'b0;
        b.i_num_split = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(b.o_busy), 0);
        chk("rst_done", int'(b.o_done), 0);
        chk("rst_err", int'(b.o_err), 0);
        chk("rst_ntt_start", int'(b.o_ntt_start), 0);
        chk("rst_madd_start", int'(b.o_madd_start), 0);
        chk("rst_mask", int'(b.o_ntt_done_mask), 0);
        chk("rst_idx", int'(b.o_idx_split), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b0, 2, 1, -1);
        run(1'b0, 2, 2, -1);
        run(1'b1, 0, 0, -1);
        for (int i = 0; i < 24; i++)
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, -1);
        run(1'b0, 3, 0, 1);
        repeat (2) @(negedge clk);
        run(1'b0, 2, 0, -1);

`ifdef DP_SPLIT_SCHED_WDOG_EN
        @(negedge clk);
        b.i_start     = 1'b1;
        b.i_mode      = 1'b0;
        b.i_num_split = 3'd1;
        t0 = cyc + 1;
        push(K_NTT, 0, t0, 1'b0);
        push(K_DONE, -1, t0 + 15, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            b.i_start    = 1'b0;
            b.i_ntt_done = {1'b0, k == 2, k == 1};
        end
        idle_inputs();
        chk("wdog_err_sticky", int'(b.o_err), 1);
        chk("wdog_busy", int'(b.o_busy), 0);
        run(1'b0, 1, 0, -1);
        chk("wdog_err_cleared", int'(b.o_err), 0);
`else
        t0 = 0;
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), t0 * 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
